// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch read and preload bus for imem_responder
interface imem_responder_if #(
    parameter int DEPTH_W = 8
) ();
    logic               instrmem_rd;
    logic [15:0]        pc;
    logic               load_en;
    logic [DEPTH_W-1:0] load_addr;
    logic [15:0]        load_data;
    logic [15:0]        dout;
    logic               complete_instr;
    logic               busy;
    logic               addr_err;

    // Fetch stage / bench side: issues reads and preloads, consumes responses
    modport master (
        output instrmem_rd, pc, load_en, load_addr, load_data,
        input  dout, complete_instr, busy, addr_err
    );

    // Responder side
    modport slave (
        input  instrmem_rd, pc, load_en, load_addr, load_data,
        output dout, complete_instr, busy, addr_err
    );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fixed-latency instruction memory responder with preload port
module imem_responder #(
    parameter int DEPTH_W = 8,
    parameter int LATENCY = 2
) (
    input  logic             clock,
    input  logic             reset,
    imem_responder_if.slave  bus
);
    localparam int         WORDS  = 1 << DEPTH_W;
    localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);
    localparam logic [15:0] HALT  = 16'hF025;

    generate
        if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
            $error("imem_responder: LATENCY must be within 1..7");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         cnt_q;
    logic [2:0]         cnt_d;
    logic [15:0]        addr_q;
    logic [15:0]        addr_d;
    logic [15:0]        dout_q;
    logic               complete_q;
    logic               busy_q;
    logic               err_q;

    logic [15:0]        mem [WORDS];

    logic               enter_resp;
    logic [DEPTH_W-1:0] rd_idx;
    logic               out_of_range;
    logic               fwd_hit;
    logic [15:0]        rd_word;

    // Next-state logic: accept in IDLE only, count latency in WAIT, single RESP cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.instrmem_rd) begin
                    addr_d  = bus.pc;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response data is fetched on the edge that enters RESP; addr_d already holds
    // pc when LATENCY is 1. A load landing on that same edge is forwarded so it is
    // visible, while a load during the RESP cycle only affects later reads.
    always_comb begin
        enter_resp   = (state_d == RESP) && (state_q != RESP);
        rd_idx       = addr_d[DEPTH_W-1:0];
        out_of_range = (addr_d >> DEPTH_W) != 16'd0;
        fwd_hit      = bus.load_en && (bus.load_addr == rd_idx);
        rd_word      = fwd_hit ? bus.load_data : mem[rd_idx];
    end

    // State, counter, captured address and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            addr_q     <= 16'd0;
            dout_q     <= 16'd0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            complete_q <= (state_d == RESP);
            busy_q     <= (state_d != IDLE);
            err_q      <= enter_resp && out_of_range;
            if (enter_resp) begin
                dout_q <= out_of_range ? HALT : rd_word;
            end
        end
    end

    // Program storage: written in any state, never cleared by reset
    always_ff @(posedge clock) begin
        if (bus.load_en) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.dout           = dout_q;
    assign bus.complete_instr = complete_q;
    assign bus.busy           = busy_q;
    assign bus.addr_err       = err_q;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the LC-3 controller fetch stage. The fetch stage issues reads by asserting `instrmem_rd` with an address on `pc`. This block answers those reads after a fixed, parameterised latency, returning the instruction on `dout` with a one-cycle `complete_instr` strobe. It also provides a bench-side load port so test code can preload program images.

## Interface

- `DEPTH_W`, default 8: log2 of the number of 16-bit words stored (256 words).
- `LATENCY`, default 2: cycles from request acceptance to response. Legal range is 1..7; elaboration fails outside that range.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `instrmem_rd` in 1: read request from fetch, level-sensitive.
- `pc` in 16: read address, word-addressed.
- `load_en` in 1: write strobe for the preload port.
- `load_addr` in DEPTH_W: preload word address.
- `load_data` in 16: preload data.
- `dout` out 16: instruction returned.
- `complete_instr` out 1: one-cycle pulse; `dout` is valid in this cycle.
- `busy` out 1: high while a request is outstanding.
- `addr_err` out 1: one-cycle pulse alongside `complete_instr` when the requested `pc` was out of range.

## Operation

- Storage is a 2^DEPTH_W x 16 array.
  - Contents are not cleared by reset.
  - Contents are X until loaded.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: counting latency.
  - RESP: response cycle.
- IDLE transitions:
  - `instrmem_rd`=1 at an edge: capture `pc` into `addr_q`, load latency counter `cnt`=LATENCY-1, go to WAIT. If LATENCY=1, go directly to RESP.
  - `instrmem_rd`=0: stay in IDLE.
- WAIT: decrement `cnt` each cycle; go to RESP when `cnt` reaches 1.
- RESP:
  - `complete_instr`=1.
  - `dout` = array[`addr_q[DEPTH_W-1:0]`], or 16'hF025 (TRAP x25, HALT) if `addr_q[15:DEPTH_W]` != 0. In the out-of-range case `addr_err`=1.
  - Next state is always IDLE. A request present during RESP is not accepted; the earliest next acceptance is at the edge ending the following IDLE cycle.
- Requests are not queued. `instrmem_rd` and `pc` are ignored in WAIT and RESP.
- `dout` holds its last response value between responses and does not follow the array.
- Load port:
  - `load_en`=1 writes `load_data` to `load_addr` at the edge.
  - Writes are accepted in every state.
- Array read timing:
  - The array is read at the response edge, not at acceptance. A load that completes before the RESP cycle is visible in the response.
  - A load in the same cycle as RESP to the same address is read-before-write: the response returns the old data, and the new data applies to later reads.
- Reset asserted (low), at any time:
  - Returns to IDLE.
  - `dout`=16'h0000, `complete_instr`=0, `busy`=0, `addr_err`=0, `cnt`=0, `addr_q`=0.
  - Any outstanding request is dropped with no `complete_instr`.
  - A load at the same edge as reset assertion is not guaranteed.

## Timing

- Request sampled high at edge N (in IDLE) gives `complete_instr` high for exactly cycle N+LATENCY (between edges N+LATENCY-1 and N+LATENCY). `dout` is valid in that cycle and after.
- `busy` is high from after edge N through the RESP cycle inclusive, so it deasserts together with `complete_instr`.
- With `instrmem_rd` held high continuously, back-to-back throughput is one response per LATENCY+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset release: the first request can be sampled at the first rising edge after `reset` goes high.

## Test plan

- **Preload and single read.** Preload addr 0x10 with 0x1234, LATENCY=2. Pulse `instrmem_rd` with `pc`=0x0010 at edge 5 → `complete_instr` high in cycle 7 only, `dout`=0x1234, `busy` high for cycles 6–7.
- **Held request / throughput.** Hold `instrmem_rd`=1 with `pc` stepping 0x3000→0x0000, 0x0001 (DEPTH_W=8, preloaded 0xAAAA, 0xBBBB) → 0x3000 returns 0xF025 with `addr_err`; remaining responses 0xAAAA, 0xBBBB, spaced 3 cycles apart; `pc` changes during WAIT are ignored.
- **Load/read interaction.** Request addr 0x20 (old data 0x1111).
  - Load 0x2222 to 0x20 during WAIT → response is 0x2222.
  - Repeat with the load landing in the RESP cycle → response is 0x1111; the next read returns 0x2222.
- **Reset mid-operation.** Request accepted, then `reset` asserted low asynchronously between edges during WAIT → `busy`, `complete_instr`, `dout` go to 0 immediately with no response pulse. After release, a fresh request completes normally and preloaded contents are intact.
- **LATENCY=1 and LATENCY=7 builds.** Same preload/read → `complete_instr` at N+1 and N+7 respectively. `dout` holds its value across a 10-cycle idle gap.
- **Idle behaviour.** `instrmem_rd`=0 for 20 cycles with `load_en` toggling → no `complete_instr`, `busy` stays 0, `dout` unchanged.
